ex_stage_exmem: RTL

//  Execute stage and EX/MEM pipeline register of the pipelined MIPS datapath.

---
 rtl/ex_stage_exmem.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage_exmem.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_exmem
// Brief    : MIPS execute stage (ALU, branch target, dest select) followed by
//            the EX/MEM pipeline register with stall hold and flush bubble.
//            Optional macro EX_FWD_EN adds operand forwarding muxes.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_exmem #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [5:0]    ex_i,
    input  logic [2:0]    m_i,
    input  logic [1:0]    wb_i,
    input  logic [DW-1:0] add1_i,
    input  logic [DW-1:0] rd1_i,
    input  logic [DW-1:0] rd2_i,
    input  logic [DW-1:0] signext_i,
    input  logic [RW-1:0] rt_i,
    input  logic [RW-1:0] rd_i,
`ifdef EX_FWD_EN
    input  logic [1:0]    fwd_a_sel,
    input  logic [1:0]    fwd_b_sel,
    input  logic [DW-1:0] exmem_fwd_i,
    input  logic [DW-1:0] memwb_fwd_i,
`endif
    output logic [2:0]    m_o,
    output logic [1:0]    wb_o,
    output logic [DW-1:0] br_target_o,
    output logic          zero_o,
    output logic [DW-1:0] alu_o,
    output logic [DW-1:0] wdata_o,
    output logic [RW-1:0] dest_o,
    output logic          valid_o
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_XOR = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_SLL = 4'b1000;
    localparam logic [3:0] c_OP_SRL = 4'b1001;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    logic          w_alu_src;
    logic [3:0]    w_alu_op;
    logic          w_reg_dst;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_fwd_b;
    logic [DW-1:0] w_op_b;
    logic [4:0]    w_shamt;

    logic [2:0]    m_d,      m_q;
    logic [1:0]    wb_d,     wb_q;
    logic [DW-1:0] br_d,     br_q;
    logic          zero_d,   zero_q;
    logic [DW-1:0] alu_d,    alu_q;
    logic [DW-1:0] wdata_d,  wdata_q;
    logic [RW-1:0] dest_d,   dest_q;
    logic          valid_q;

    assign w_alu_src = ex_i[5];
    assign w_alu_op  = ex_i[4:1];
    assign w_reg_dst = ex_i[0];

`ifdef EX_FWD_EN
    // Bit 1 set (10 or 11) selects the EX/MEM path so it wins over MEM/WB.
    always_comb begin
        w_op_a = rd1_i;
        if (fwd_a_sel[1])      w_op_a = exmem_fwd_i;
        else if (fwd_a_sel[0]) w_op_a = memwb_fwd_i;
    end

    always_comb begin
        w_fwd_b = rd2_i;
        if (fwd_b_sel[1])      w_fwd_b = exmem_fwd_i;
        else if (fwd_b_sel[0]) w_fwd_b = memwb_fwd_i;
    end
`else
    assign w_op_a  = rd1_i;
    assign w_fwd_b = rd2_i;
`endif

    assign w_op_b  = w_alu_src ? signext_i : w_fwd_b;
    assign w_shamt = w_op_a[4:0];

    always_comb begin
        alu_d = '0;
        case (w_alu_op)
            c_OP_AND: alu_d = w_op_a & w_op_b;
            c_OP_OR:  alu_d = w_op_a | w_op_b;
            c_OP_ADD: alu_d = w_op_a + w_op_b;
            c_OP_XOR: alu_d = w_op_a ^ w_op_b;
            c_OP_SUB: alu_d = w_op_a - w_op_b;
            c_OP_SLT: alu_d = {{(DW-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            c_OP_SLL: alu_d = w_op_b << w_shamt;
            c_OP_SRL: alu_d = w_op_b >> w_shamt;
            c_OP_NOR: alu_d = ~(w_op_a | w_op_b);
            default:  alu_d = '0;
        endcase
    end

    assign zero_d  = (alu_d == '0);
    // Word offset: the top two immediate bits fall off the left edge.
    assign br_d    = add1_i + {signext_i[DW-3:0], 2'b00};
    assign wdata_d = w_fwd_b;
    assign dest_d  = w_reg_dst ? rd_i : rt_i;
    assign m_d     = m_i;
    assign wb_d    = wb_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            wb_q    <= '0;
            br_q    <= '0;
            zero_q  <= 1'b0;
            alu_q   <= '0;
            wdata_q <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
        end else if (stall) begin
            m_q     <= m_q;
            wb_q    <= wb_q;
            br_q    <= br_q;
            zero_q  <= zero_q;
            alu_q   <= alu_q;
            wdata_q <= wdata_q;
            dest_q  <= dest_q;
            valid_q <= valid_q;
        end else if (flush) begin
            m_q     <= '0;
            wb_q    <= '0;
            br_q    <= '0;
            zero_q  <= 1'b0;
            alu_q   <= '0;
            wdata_q <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            m_q     <= m_d;
            wb_q    <= wb_d;
            br_q    <= br_d;
            zero_q  <= zero_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            dest_q  <= dest_d;
            valid_q <= 1'b1;
        end
    end

    assign m_o         = m_q;
    assign wb_o        = wb_q;
    assign br_target_o = br_q;
    assign zero_o      = zero_q;
    assign alu_o       = alu_q;
    assign wdata_o     = wdata_q;
    assign dest_o      = dest_q;
    assign valid_o     = valid_q;

endmodule
`default_nettype wire
